// File: rtl/paged_ram_pkg.sv
// Shared definitions for the double-buffered paged frame RAM.
// Holds the control FSM encoding and the default geometry constants.
package paged_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pdp_ram_core.sv
// Single-clock simple dual-port array: one write port, one registered read port.
// Only the read register is reset; the array itself keeps its contents.
module pdp_ram_core
    import paged_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem_array [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] read_data_reg;

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_array[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_reg <= '0;
        end else if (read_en) begin
            read_data_reg <= mem_array[read_addr];
        end
    end

    assign read_data = read_data_reg;

endmodule

// File: rtl/paged_pdp_ram.sv
// Two-page frame buffer: scan logic reads the front page while the back page is
// written or cleared; pages exchange only at a frame boundary while not clearing.
module paged_pdp_ram
    import paged_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    input  logic                  frame_end,
    input  logic                  swap_req,
    output logic                  swap_pending,
    output logic                  swap_done,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  front_page
);

    ctrl_state_t           state_reg,        state_next;
    logic [ADDR_WIDTH-1:0] counter_reg,      counter_next;
    logic                  front_page_reg,   front_page_next;
    logic                  swap_pending_reg, swap_pending_next;
    logic                  swap_done_reg,    swap_done_next;
    logic                  read_valid_reg;
    logic                  swap_fire;
    logic                  clearing;

    logic                  mem_write_en;
    logic [ADDR_WIDTH:0]   mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic [ADDR_WIDTH:0]   mem_read_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            counter_reg      <= '0;
            front_page_reg   <= 1'b0;
            swap_pending_reg <= 1'b0;
            swap_done_reg    <= 1'b0;
            read_valid_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            counter_reg      <= counter_next;
            front_page_reg   <= front_page_next;
            swap_pending_reg <= swap_pending_next;
            swap_done_reg    <= swap_done_next;
            read_valid_reg   <= read_en;
        end
    end

    always_comb begin
        state_next        = state_reg;
        counter_next      = counter_reg;
        front_page_next   = front_page_reg;
        swap_pending_next = swap_pending_reg;
        swap_fire         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                swap_fire = frame_end && (swap_pending_reg || swap_req);
                // A clear started alongside a swap sees the toggled page next cycle.
                if (clear_req) begin
                    state_next   = ST_CLEAR;
                    counter_next = '0;
                end
            end
            ST_CLEAR: begin
                counter_next = counter_reg + 1'b1;
                if (counter_reg == '1) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (swap_fire) begin
            front_page_next   = ~front_page_reg;
            swap_pending_next = 1'b0;
        end else if (swap_req) begin
            swap_pending_next = 1'b1;
        end
        swap_done_next = swap_fire;
    end

    assign clearing       = (state_reg == ST_CLEAR);
    assign mem_write_en   = clearing || write_en;
    assign mem_write_addr = {~front_page_reg, (clearing ? counter_reg : write_addr)};
    assign mem_write_data = clearing ? CLEAR_VALUE : write_data;
    // Reads on a swap edge still use the page that was front before the edge.
    assign mem_read_addr  = {front_page_reg, read_addr};

    pdp_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH + 1)
    ) u_core (
        .clk        (clk),
        .reset_n    (reset_n),
        .write_en   (mem_write_en),
        .write_addr (mem_write_addr),
        .write_data (mem_write_data),
        .read_en    (read_en),
        .read_addr  (mem_read_addr),
        .read_data  (read_data)
    );

    assign read_valid   = read_valid_reg;
    assign swap_pending = swap_pending_reg;
    assign swap_done    = swap_done_reg;
    assign busy         = clearing;
    assign front_page   = front_page_reg;

endmodule

// File: tb/tb_paged_pdp_ram.sv
// Directed bench for paged_pdp_ram with a 16-word page and 0xFF clear word.
module tb_paged_pdp_ram;

    logic       clk;
    logic       reset_n;
    logic [3:0] write_addr;
    logic [7:0] write_data;
    logic       write_en;
    logic [3:0] read_addr;
    logic       read_en;
    logic [7:0] read_data;
    logic       read_valid;
    logic       frame_end;
    logic       swap_req;
    logic       swap_pending;
    logic       swap_done;
    logic       clear_req;
    logic       busy;
    logic       front_page;

    int total = 0;
    int bad   = 0;
    int busy_cycles;

    paged_pdp_ram #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .CLEAR_VALUE (8'hFF)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_en     (write_en),
        .read_addr    (read_addr),
        .read_en      (read_en),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .frame_end    (frame_end),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .clear_req    (clear_req),
        .busy         (busy),
        .front_page   (front_page)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [7:0] exp);
        read_en   = 1'b1;
        read_addr = a;
        tick();
        read_en   = 1'b0;
        check({tag, "_valid"}, read_valid, 1);
        check(tag, read_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        write_addr = '0;
        write_data = '0;
        write_en   = 1'b0;
        read_addr  = '0;
        read_en    = 1'b0;
        frame_end  = 1'b0;
        swap_req   = 1'b0;
        clear_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read_data", read_data, 0);
        check("rst_read_valid", read_valid, 0);
        check("rst_front_page", front_page, 0);
        check("rst_busy", busy, 0);
        check("rst_swap_pending", swap_pending, 0);
        check("rst_swap_done", swap_done, 0);
        reset_n = 1'b1;
        tick();

        // Basic write, immediate swap, read back
        do_write(4'd3, 8'h5A);
        swap_req = 1'b1; frame_end = 1'b1;
        tick();
        swap_req = 1'b0; frame_end = 1'b0;
        check("imm_swap_done", swap_done, 1);
        check("imm_swap_pending", swap_pending, 0);
        check("imm_front_page", front_page, 1);
        tick();
        check("imm_swap_done_drop", swap_done, 0);
        do_read("rd_5a", 4'd3, 8'h5A);
        tick();
        check("rd_valid_drop", read_valid, 0);
        check("rd_data_hold", read_data, 8'h5A);

        // Deferred swap: request, wait 10 cycles, then frame_end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        check("pend_set", swap_pending, 1);
        for (int i = 0; i < 9; i++) begin
            swap_req = (i == 4);
            tick();
            swap_req = 1'b0;
            check("pend_hold", swap_pending, 1);
        end
        check("pend_front_unchanged", front_page, 1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("def_front_page", front_page, 0);
        check("def_swap_done", swap_done, 1);
        check("def_pend_clear", swap_pending, 0);
        tick();
        check("def_swap_done_drop", swap_done, 0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("no_queued_swap", front_page, 0);

        // Clear of back page 1 with writes and a second clear_req while busy
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clr_busy_start", busy, 1);
        busy_cycles = 1;
        for (int n = 0; n < 40 && busy; n++) begin
            write_en   = 1'b1;
            write_addr = 4'(n);
            write_data = 8'h11;
            clear_req  = (n == 3);
            tick();
            if (busy) busy_cycles++;
        end
        write_en  = 1'b0;
        clear_req = 1'b0;
        check("clr_busy_cycles", busy_cycles, 16);
        swap_req = 1'b1; frame_end = 1'b1;
        tick();
        swap_req = 1'b0; frame_end = 1'b0;
        check("clr_swap_front", front_page, 1);
        for (int i = 0; i < 16; i++) begin
            do_read("clr_word", 4'(i), 8'hFF);
        end

        // Read on the swap edge uses the old front page
        do_write(4'd2, 8'hA2);
        read_en = 1'b1; read_addr = 4'd2;
        swap_req = 1'b1; frame_end = 1'b1;
        tick();
        read_en = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
        check("swapedge_valid", read_valid, 1);
        check("swapedge_old_page", read_data, 8'hFF);
        check("swapedge_front", front_page, 0);
        do_read("swapedge_new_page", 4'd2, 8'hA2);

        // frame_end during clear must not swap
        swap_req = 1'b1; clear_req = 1'b1;
        tick();
        swap_req = 1'b0; clear_req = 1'b0;
        check("cs_pending", swap_pending, 1);
        check("cs_busy", busy, 1);
        repeat (3) tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("cs_no_swap_front", front_page, 0);
        check("cs_still_pending", swap_pending, 1);
        check("cs_no_swap_done", swap_done, 0);
        for (int n = 0; n < 40 && busy; n++) tick();
        check("cs_busy_fell", busy, 0);
        check("cs_front_after_clear", front_page, 0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check("cs_swap_front", front_page, 1);
        check("cs_swap_done", swap_done, 1);
        check("cs_pend_clear", swap_pending, 0);

        // Reset during a clear leaves page 0 partially cleared
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 8'h30 + 8'(i));
        end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (5) tick();
        check("mid_clr_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_front", front_page, 0);
        check("mid_rst_read_data", read_data, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin
            do_read("part_clr_word", 4'(i), (i < 5) ? 8'hFF : (8'h30 + 8'(i)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paged_pdp_ram.md
PAGED_PDP_RAM -- requirements
Module: paged_pdp_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one pixel word.
REQ-002 Parameter ADDR_WIDTH, default 10, address width of one page; DEPTH = 2**ADDR_WIDTH words per page.
REQ-003 Parameter CLEAR_VALUE, default 0, word written by a page clear.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 write_addr  input  ADDR_WIDTH  word address in back page.
REQ-007 write_data  input  DATA_WIDTH  word to store.
REQ-008 write_en  input  1  write strobe.
REQ-009 read_addr  input  ADDR_WIDTH  word address in front page.
REQ-010 read_en  input  1  read strobe.
REQ-011 read_data  output  DATA_WIDTH  registered read word.
REQ-012 read_valid  output  1  read_data updated this cycle.
REQ-013 frame_end  input  1  one-cycle pulse from scan logic at frame boundary.
REQ-014 swap_req  input  1  pulse requesting front/back exchange.
REQ-015 swap_pending  output  1  swap requested, not yet executed.
REQ-016 swap_done  output  1  one-cycle pulse, first cycle with new front_page.
REQ-017 clear_req  input  1  pulse requesting back-page fill with CLEAR_VALUE.
REQ-018 busy  output  1  clear in progress.
REQ-019 front_page  output  1  index of page currently read.

Function
REQ-020 Storage SHALL be 2*DEPTH words; physical address = {page, addr}.
REQ-021 write_en with busy=0 SHALL store write_data at {~front_page, write_addr} on the clock edge; write_en with busy=1 SHALL be dropped.
REQ-022 read_en SHALL load read_data from {front_page, read_addr} with one-cycle latency and assert read_valid for exactly that following cycle; otherwise read_valid=0 and read_data holds.
REQ-023 Reads and writes SHALL never address the same page; read-during-write needs no bypass.
REQ-024 Control FSM SHALL have states IDLE and CLEAR.
REQ-025 IDLE + clear_req: enter CLEAR, counter=0, busy=1 from next cycle.
REQ-026 CLEAR SHALL write CLEAR_VALUE to {~front_page, counter} once per cycle, counter 0..DEPTH-1 (DEPTH cycles), then return to IDLE with busy=0 in the following cycle.
REQ-027 clear_req while in CLEAR SHALL be ignored.
REQ-028 swap_req SHALL set swap_pending in any state; repeated swap_req while pending SHALL not queue a second swap.
REQ-029 Swap SHALL execute on an edge where state=IDLE, frame_end=1 and (swap_pending=1 or swap_req=1): front_page toggles, swap_pending clears, swap_done=1 next cycle.
REQ-030 swap_req and frame_end in the same IDLE cycle SHALL swap immediately; swap_pending never asserts.
REQ-031 frame_end during CLEAR SHALL not swap; the swap waits for the first frame_end in IDLE.
REQ-032 clear_req and swap-eligible frame_end in the same IDLE cycle: swap first, then clear targets the new back page.
REQ-033 A read_en on the swap edge SHALL use the old front_page.

Reset
REQ-034 reset_n low SHALL immediately force: state IDLE, counter 0, front_page 0, read_data 0, read_valid 0, swap_pending 0, swap_done 0, busy 0.
REQ-035 Memory contents SHALL not be reset; a clear interrupted by reset leaves the page partially cleared.

Structure
REQ-036 Shared package paged_ram_pkg SHALL hold FSM state encoding and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-037 Storage SHALL be a sub-module pdp_ram_core (parameterised single-clock simple dual-port array, registered read); control logic lives in paged_pdp_ram.

Verification
REQ-038 After reset, write 0x5A to addr 3, swap_req + frame_end, read addr 3 -> read_data=0x5A, read_valid=1 one cycle after read_en; swap_done pulses once; front_page=1.
REQ-039 swap_req at cycle 10, frame_end at cycle 20 -> swap_pending high cycles 11-20, front_page toggles on edge 20, swap_done high cycle 21 only.
REQ-040 ADDR_WIDTH=4, CLEAR_VALUE=0xFF, clear_req -> busy high exactly 16 cycles; all 16 back-page words read 0xFF after swap; writes issued while busy absent.
REQ-041 frame_end during clear with swap_pending=1 -> no swap; next frame_end after busy falls -> swap.
REQ-042 reset_n low mid-clear at counter=5 -> busy=0, state IDLE immediately; words 0-4 cleared, 5+ keep prior data.
REQ-043 read_en on swap edge -> read_data from old front page; next read from new front page.
